// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU state dumper.
package cpu_dbg_pkg;

   // Frame sections: idle, header words, register file, data memory
   typedef enum logic [1:0] {
      IDLE,
      HDR,
      REG,
      MEM
   } dump_state_e;

   localparam int unsigned HDR_WORDS = 4;

   // Header word positions within the HDR section
   localparam logic [1:0] HDR_CYCLE = 2'd0;
   localparam logic [1:0] HDR_PC    = 2'd1;
   localparam logic [1:0] HDR_STALL = 2'd2;
   localparam logic [1:0] HDR_FLUSH = 2'd3;

endpackage

// File: rtl/perf_counters.sv
// Cycle, stall and flush counters with a snapshot taken on request.
module perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_en,
   input  logic        stall,
   input  logic        branch,
   input  logic        flush,
   input  logic        snap,
   output logic [31:0] cycle_snap,
   output logic [31:0] stall_snap,
   output logic [31:0] flush_snap
);

   logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
   logic [31:0] cycle_next, stall_next, flush_next;

   // Next counter values; the snapshot captures these so it includes the request edge
   always_comb begin
      cycle_next = cycle_cnt;
      stall_next = stall_cnt;
      flush_next = flush_cnt;
      if (count_en) begin
         cycle_next = cycle_cnt + 32'd1;
         // Stalls raised for a branch are not real data hazards
         if (stall && !branch) stall_next = stall_cnt + 32'd1;
         if (flush) flush_next = flush_cnt + 32'd1;
      end
   end

   // Counter and snapshot registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt  <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         cycle_snap <= '0;
         stall_snap <= '0;
         flush_snap <= '0;
      end else begin
         cycle_cnt <= cycle_next;
         stall_cnt <= stall_next;
         flush_cnt <= flush_next;
         if (snap) begin
            cycle_snap <= cycle_next;
            stall_snap <= stall_next;
            flush_snap <= flush_next;
         end
      end
   end

endmodule

// File: rtl/cpu_state_dumper.sv
// Freezes the CPU on request and streams a header, register file and data memory as one frame.
module cpu_state_dumper
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned DMEM_WORDS = 8,
   parameter int unsigned NUM_REGS   = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic        flush_i,
   input  logic        dump_req_i,
   output logic        cpu_hold_o,
   output logic [4:0]  reg_addr_o,
   input  logic [31:0] reg_data_i,
   output logic [4:0]  mem_addr_o,
   input  logic [31:0] mem_data_i,
   output logic [31:0] tx_data_o,
   output logic        tx_valid_o,
   output logic        tx_last_o,
   input  logic        tx_ready_i
);

   dump_state_e state;
   logic [4:0]  idx;
   logic        pending;
   logic [31:0] pc_snap;
   logic [31:0] cycle_snap, stall_snap, flush_snap;
   logic        handshake;
   logic        accept;
   logic        count_en;

   assign handshake = tx_valid_o && tx_ready_i;
   assign accept    = (state == IDLE) && (dump_req_i || pending);
   assign count_en  = start_i && !cpu_hold_o;

   perf_counters u_counters (
      .clk        (clk_i),
      .rst        (rst_i),
      .count_en   (count_en),
      .stall      (stall_i),
      .branch     (branch_i),
      .flush      (flush_i),
      .snap       (accept),
      .cycle_snap (cycle_snap),
      .stall_snap (stall_snap),
      .flush_snap (flush_snap)
   );

   // Frame word mux; register and memory data come straight from the held CPU's read ports
   always_comb begin
      tx_data_o = '0;
      unique case (state)
         HDR: begin
            case (idx[1:0])
               HDR_CYCLE: tx_data_o = cycle_snap;
               HDR_PC:    tx_data_o = pc_snap;
               HDR_STALL: tx_data_o = stall_snap;
               HDR_FLUSH: tx_data_o = flush_snap;
               default:   tx_data_o = '0;
            endcase
         end
         REG:     tx_data_o = reg_data_i;
         MEM:     tx_data_o = mem_data_i;
         default: tx_data_o = '0;
      endcase
   end

   // Dump sequencer with registered hold, valid, last and read addresses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         idx        <= '0;
         pending    <= 1'b0;
         pc_snap    <= '0;
         cpu_hold_o <= 1'b0;
         tx_valid_o <= 1'b0;
         tx_last_o  <= 1'b0;
         reg_addr_o <= '0;
         mem_addr_o <= '0;
      end else begin
         // One-deep request queue while a frame is in flight
         if (state != IDLE && dump_req_i) pending <= 1'b1;

         unique case (state)
            IDLE: begin
               if (accept) begin
                  state      <= HDR;
                  idx        <= '0;
                  pending    <= 1'b0;
                  pc_snap    <= pc_i;
                  cpu_hold_o <= 1'b1;
                  tx_valid_o <= 1'b1;
                  tx_last_o  <= 1'b0;
               end
            end
            HDR: begin
               if (handshake) begin
                  if (idx == 5'(HDR_WORDS - 1)) begin
                     state      <= REG;
                     idx        <= '0;
                     reg_addr_o <= '0;
                  end else begin
                     idx <= idx + 5'd1;
                  end
               end
            end
            REG: begin
               if (handshake) begin
                  if (idx == 5'(NUM_REGS - 1)) begin
                     state      <= MEM;
                     idx        <= '0;
                     mem_addr_o <= '0;
                     tx_last_o  <= (DMEM_WORDS == 1);
                  end else begin
                     idx        <= idx + 5'd1;
                     reg_addr_o <= idx + 5'd1;
                  end
               end
            end
            MEM: begin
               if (handshake) begin
                  if (idx == 5'(DMEM_WORDS - 1)) begin
                     state      <= IDLE;
                     idx        <= '0;
                     reg_addr_o <= '0;
                     mem_addr_o <= '0;
                     cpu_hold_o <= 1'b0;
                     tx_valid_o <= 1'b0;
                     tx_last_o  <= 1'b0;
                  end else begin
                     idx        <= idx + 5'd1;
                     mem_addr_o <= idx + 5'd1;
                     tx_last_o  <= (idx + 5'd1 == 5'(DMEM_WORDS - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
